alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_pkg.sv | 32 +++
 rtl/alu_issue_ctrl_if.sv | 63 ++++++
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: parameter defaults,
// FSM state encoding and response flag bit positions.
package alu_issue_pkg;

    localparam int LENGTH_DEF = 32;
    localparam int TAG_W_DEF  = 4;

    // Bit positions inside the 4-bit response flag vector.
    localparam int FLAG_CARRY = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_SIGN  = 1;
    localparam int FLAG_OVF   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Pack the individual ALU flags into the response flag layout.
    function automatic logic [3:0] pack_flags(input logic carry, input logic zero,
                                              input logic sign, input logic ovf);
        logic [3:0] f;
        f             = '0;
        f[FLAG_CARRY] = carry;
        f[FLAG_ZERO]  = zero;
        f[FLAG_SIGN]  = sign;
        f[FLAG_OVF]   = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of command, response, external-ALU and status signals around
// alu_issue_ctrl. slave = controller view, master = environment view.
interface alu_issue_ctrl_if
    import alu_issue_pkg::*;
#(
    parameter int LENGTH = LENGTH_DEF,
    parameter int TAG_W  = TAG_W_DEF
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_opcode;
    logic [LENGTH-1:0] cmd_a;
    logic [LENGTH-1:0] cmd_b;
    logic              cmd_chain;
    logic [TAG_W-1:0]  cmd_tag;

    // external ALU
    logic [LENGTH-1:0] alu_op1;
    logic [LENGTH-1:0] alu_op2;
    logic              alu_mode;
    logic [2:0]        alu_operation;
    logic [LENGTH-1:0] alu_out;
    logic              alu_carry;
    logic              alu_zero;
    logic              alu_sign;
    logic              alu_overflow;

    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [LENGTH-1:0] rsp_result;
    logic [3:0]        rsp_flags;
    logic [TAG_W-1:0]  rsp_tag;

    // status
    logic              ovf_sticky;
    logic              clr_sticky;
    logic [15:0]       op_count;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain, cmd_tag,
        output cmd_ready,
        output alu_op1, alu_op2, alu_mode, alu_operation,
        input  alu_out, alu_carry, alu_zero, alu_sign, alu_overflow,
        output rsp_valid, rsp_result, rsp_flags, rsp_tag,
        input  rsp_ready,
        output ovf_sticky, op_count,
        input  clr_sticky
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain, cmd_tag,
        input  cmd_ready,
        input  alu_op1, alu_op2, alu_mode, alu_operation,
        output alu_out, alu_carry, alu_zero, alu_sign, alu_overflow,
        input  rsp_valid, rsp_result, rsp_flags, rsp_tag,
        output rsp_ready,
        input  ovf_sticky, op_count,
        output clr_sticky
    );

endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU. Accepts one command,
// registers the ALU operands for one DRIVE cycle, captures the result and
// holds it on the response channel until taken.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int LENGTH = LENGTH_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input logic            clk,
    input logic            rst,
    alu_issue_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] DRIVE = ST_DRIVE;
    localparam logic [1:0] RESP  = ST_RESP;

    logic [1:0]        state;
    logic [LENGTH-1:0] op1_q;
    logic [LENGTH-1:0] op2_q;
    logic              mode_q;
    logic [2:0]        oper_q;
    logic [TAG_W-1:0]  tag_q;
    logic [LENGTH-1:0] acc_q;
    logic [LENGTH-1:0] result_q;
    logic [3:0]        flags_q;
    logic              sticky_q;
    logic [15:0]       op_count_q;

    logic              accept;
    logic              capture;
    logic              complete;
    logic [3:0]        alu_flags;

    assign accept    = bus.cmd_valid && (state == IDLE);
    assign capture   = (state == DRIVE);
    assign complete  = (state == RESP) && bus.rsp_ready;
    assign alu_flags = pack_flags(bus.alu_carry, bus.alu_zero, bus.alu_sign, bus.alu_overflow);

    // Three-state issue sequence; DRIVE is always exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= DRIVE;
                DRIVE:   state <= RESP;
                RESP:    if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ALU-facing operand/control registers load only on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1_q  <= '0;
            op2_q  <= '0;
            mode_q <= 1'b0;
            oper_q <= '0;
            tag_q  <= '0;
        end else if (accept) begin
            op1_q  <= bus.cmd_chain ? acc_q : bus.cmd_a;
            op2_q  <= bus.cmd_b;
            mode_q <= bus.cmd_opcode[3];
            oper_q <= bus.cmd_opcode[2:0];
            tag_q  <= bus.cmd_tag;
        end
    end

    // Sample the ALU at the end of DRIVE; the accumulator tracks the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            acc_q    <= '0;
        end else if (capture) begin
            result_q <= bus.alu_out;
            flags_q  <= alu_flags;
            acc_q    <= bus.alu_out;
        end
    end

    // Sticky overflow: a capture with overflow beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (capture && bus.alu_overflow) begin
            sticky_q <= 1'b1;
        end else if (bus.clr_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    // Count responses actually taken by the consumer; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (complete) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign bus.cmd_ready     = (state == IDLE);
    assign bus.alu_op1       = op1_q;
    assign bus.alu_op2       = op2_q;
    assign bus.alu_mode      = mode_q;
    assign bus.alu_operation = oper_q;
    assign bus.rsp_valid     = (state == RESP);
    assign bus.rsp_result    = result_q;
    assign bus.rsp_flags     = flags_q;
    assign bus.rsp_tag       = tag_q;
    assign bus.ovf_sticky    = sticky_q;
    assign bus.op_count      = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an adder ALU stub on the alu_* side.
module tb_alu_issue_ctrl;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU stub: 32-bit adder with carry, zero, sign and signed overflow.
    logic [32:0] sum;
    assign sum              = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
    assign bus.alu_out      = sum[31:0];
    assign bus.alu_carry    = sum[32];
    assign bus.alu_zero     = (sum[31:0] == 32'd0);
    assign bus.alu_sign     = sum[31];
    assign bus.alu_overflow = (bus.alu_op1[31] == bus.alu_op2[31]) && (sum[31] != bus.alu_op1[31]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_cmd(input logic [31:0] a, input logic [31:0] b, input logic chain,
                             input logic [3:0] opc, input logic [3:0] tag);
        bus.cmd_valid  = 1'b1;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_chain  = chain;
        bus.cmd_opcode = opc;
        bus.cmd_tag    = tag;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_chain = 0;
        bus.cmd_opcode = 0; bus.cmd_tag = 0; bus.rsp_ready = 0; bus.clr_sticky = 0;
        @(negedge clk);
        tests++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.ovf_sticky, bus.op_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL reset_status: got rdy=%b vld=%b stk=%b cnt=%h, want 1 0 0 0000",
                     bus.cmd_ready, bus.rsp_valid, bus.ovf_sticky, bus.op_count);
        end
        tests++;
        if ({bus.alu_op1, bus.alu_op2, bus.alu_mode, bus.alu_operation, bus.rsp_result,
             bus.rsp_flags, bus.rsp_tag} !== '0) begin
            fails++;
            $display("FAIL reset_regs: got op1=%h op2=%h res=%h flags=%b tag=%h, want all 0",
                     bus.alu_op1, bus.alu_op2, bus.rsp_result, bus.rsp_flags, bus.rsp_tag);
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        tests++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: got %b want 1", bus.cmd_ready);
        end
        drive_cmd(32'd5, 32'd7, 1'b0, 4'b1010, 4'd3);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tests++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.alu_op1, bus.alu_op2, bus.alu_mode, bus.alu_operation}
            !== {1'b0, 1'b0, 32'd5, 32'd7, 1'b1, 3'b010}) begin
            fails++;
            $display("FAIL single_drive: got vld=%b rdy=%b op1=%h op2=%h mode=%b op=%b, want 0 0 5 7 1 010",
                     bus.rsp_valid, bus.cmd_ready, bus.alu_op1, bus.alu_op2, bus.alu_mode, bus.alu_operation);
        end
        @(negedge clk);
        tests++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_tag} !== {1'b1, 32'd12, 4'b0000, 4'd3}) begin
            fails++;
            $display("FAIL single_rsp: got vld=%b res=%h flags=%b tag=%h, want 1 0000000c 0000 3",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_tag);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        tests++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.op_count} !== {1'b0, 1'b1, 16'd1}) begin
            fails++;
            $display("FAIL single_done: got vld=%b rdy=%b cnt=%h, want 0 1 0001",
                     bus.rsp_valid, bus.cmd_ready, bus.op_count);
        end
    endtask

    task automatic test_overflow_sticky;
        drive_cmd(32'h7FFF_FFFF, 32'd1, 1'b0, 4'd0, 4'd5);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.rsp_result, bus.rsp_flags, bus.ovf_sticky} !== {32'h8000_0000, 4'b0011, 1'b1}) begin
            fails++;
            $display("FAIL ovf_rsp: got res=%h flags=%b stk=%b, want 80000000 0011 1",
                     bus.rsp_result, bus.rsp_flags, bus.ovf_sticky);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        // second overflow with clear held across accept and capture edges
        bus.clr_sticky = 1'b1;
        drive_cmd(32'h7FFF_FFFF, 32'd1, 1'b0, 4'd0, 4'd6);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tests++;
        if (bus.ovf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL sticky_clear: got %b want 0", bus.ovf_sticky);
        end
        @(negedge clk);
        tests++;
        if (bus.ovf_sticky !== 1'b1) begin
            fails++;
            $display("FAIL sticky_set_wins: got %b want 1", bus.ovf_sticky);
        end
        bus.clr_sticky = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.clr_sticky = 1'b1;
        @(negedge clk);
        bus.clr_sticky = 1'b0;
        tests++;
        if ({bus.ovf_sticky, bus.op_count} !== {1'b0, 16'd3}) begin
            fails++;
            $display("FAIL sticky_idle_clear: got stk=%b cnt=%h, want 0 0003", bus.ovf_sticky, bus.op_count);
        end
    endtask

    task automatic test_backpressure;
        drive_cmd(32'd100, 32'd23, 1'b0, 4'd0, 4'd9);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        // a competing command stays pending the whole time and must not be taken
        drive_cmd(32'd1, 32'd1, 1'b0, 4'd0, 4'd2);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_tag, bus.cmd_ready}
                !== {1'b1, 32'd123, 4'b0000, 4'd9, 1'b0}) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b res=%h flags=%b tag=%h rdy=%b, want 1 0000007b 0000 9 0",
                         i, bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_tag, bus.cmd_ready);
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        tests++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.op_count, bus.alu_op1} !== {1'b0, 1'b1, 16'd4, 32'd100}) begin
            fails++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b cnt=%h op1=%h, want 0 1 0004 00000064",
                     bus.rsp_valid, bus.cmd_ready, bus.op_count, bus.alu_op1);
        end
    endtask

    task automatic test_chain;
        drive_cmd(32'd10, 32'd20, 1'b0, 4'd0, 4'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive_cmd(32'd999, 32'd5, 1'b1, 4'd0, 4'd2);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tests++;
        if (bus.alu_op1 !== 32'd30) begin
            fails++;
            $display("FAIL chain_op1: got %h want 0000001e", bus.alu_op1);
        end
        @(negedge clk);
        tests++;
        if ({bus.rsp_result, bus.rsp_tag} !== {32'd35, 4'd2}) begin
            fails++;
            $display("FAIL chain_result: got res=%h tag=%h, want 00000023 2", bus.rsp_result, bus.rsp_tag);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive_cmd(32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0, 4'd7);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.rsp_result, bus.rsp_flags} !== {32'd0, 4'b1100}) begin
            fails++;
            $display("FAIL carry_zero: got res=%h flags=%b, want 00000000 1100", bus.rsp_result, bus.rsp_flags);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        tests++;
        if (bus.op_count !== 16'd7) begin
            fails++;
            $display("FAIL chain_count: got %h want 0007", bus.op_count);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        drive_cmd(32'd1, 32'd2, 1'b0, 4'b1111, 4'd4);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.ovf_sticky, bus.op_count, bus.alu_op1, bus.alu_op2,
             bus.alu_mode, bus.alu_operation, bus.rsp_result, bus.rsp_flags, bus.rsp_tag}
            !== {1'b1, 1'b0, 1'b0, 16'd0, 64'd0, 1'b0, 3'd0, 32'd0, 4'd0, 4'd0}) begin
            fails++;
            $display("FAIL reset_mid_clear: got rdy=%b vld=%b cnt=%h op1=%h op2=%h res=%h, want 1 0 0000 0 0 0",
                     bus.cmd_ready, bus.rsp_valid, bus.op_count, bus.alu_op1, bus.alu_op2, bus.rsp_result);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        bus.rsp_ready = 1'b0;
        tests++;
        if ({seen, bus.op_count} !== {1'b0, 16'd0}) begin
            fails++;
            $display("FAIL reset_mid_norsp: got seen=%b cnt=%h, want 0 0000", seen, bus.op_count);
        end
        // accumulator was cleared, so a chained command starts from 0
        drive_cmd(32'd77, 32'd4, 1'b1, 4'd0, 4'd8);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.alu_op1, bus.rsp_result} !== {32'd0, 32'd4}) begin
            fails++;
            $display("FAIL chain_after_reset: got op1=%h res=%h, want 00000000 00000004",
                     bus.alu_op1, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_count_wrap;
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        tests++;
        if (bus.op_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_preload: got %h want ffff", bus.op_count);
        end
        drive_cmd(32'd3, 32'd4, 1'b0, 4'd0, 4'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        tests++;
        if (bus.op_count !== 16'h0000) begin
            fails++;
            $display("FAIL wrap: got %h want 0000", bus.op_count);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        @(negedge clk);
        test_single();
        test_overflow_sticky();
        test_backpressure();
        test_chain();
        test_reset_mid();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
